// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner: one row driven low per step, whole-frame debounce with ghost
// rejection, accepted key codes queued in a FIFO with an interrupt pulse per accepted key.
module keypad_scan_fifo #(
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLS       = 3,
    parameter int unsigned SCAN_DIV   = 22727,
    parameter int unsigned DEBOUNCE   = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned INT_CYCLES = 3,
    localparam int unsigned CODE_W    = $clog2(ROWS * COLS)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [COLS-1:0]   COL_IN,
    output logic [ROWS-1:0]   ROW_OUT,
    output logic [CODE_W-1:0] DATA,
    output logic              VALID,
    input  logic              POP,
    output logic              INTERRUPT,
    output logic              OVERFLOW
);
    localparam int unsigned DIV_W  = $clog2(SCAN_DIV);
    localparam int unsigned ROW_W  = $clog2(ROWS);
    localparam int unsigned CNT_W  = $clog2(DEBOUNCE + 1);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned INT_W  = $clog2(INT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StCand, StHeld} state_e;

    logic [COLS-1:0]   col_meta_q, col_sync_q;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [1:0]        acc_hits_q, acc_hits_d;
    logic [CODE_W-1:0] acc_key_q, acc_key_d;
    state_e            state_q, state_d;
    logic [CODE_W-1:0] key_q, key_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, rcnt_q, rcnt_d;
    logic              push_req_q, push_req_d;
    logic [CODE_W-1:0] push_code_q, push_code_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0] count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [INT_W-1:0]  int_cnt_q, int_cnt_d;
    logic [CODE_W-1:0] fifo_mem_q [FIFO_DEPTH];

    logic              tick, frame_end, accept;
    logic [COLS-1:0]   col_low;
    logic [1:0]        row_hits, frame_hits;
    logic [2:0]        hit_sum;
    logic [CODE_W-1:0] row_key, frame_key;
    logic              fifo_empty, fifo_full, pop_en, push_en;

    assign tick      = (div_q == DIV_W'(SCAN_DIV - 1));
    assign frame_end = tick && (row_q == ROW_W'(ROWS - 1));
    assign col_low   = ~col_sync_q;

    // Low-bit count saturates at 2: the frame only needs to tell none / one / many.
    always_comb begin
        row_hits = 2'd0;
        row_key  = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            if (col_low[c]) begin
                if (row_hits == 2'd0) row_key = CODE_W'(row_q * COLS + c);
                if (row_hits != 2'd2) row_hits = row_hits + 2'd1;
            end
        end
        hit_sum    = {1'b0, acc_hits_q} + {1'b0, row_hits};
        frame_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        frame_key  = (acc_hits_q != 2'd0) ? acc_key_q : row_key;
    end

    always_comb begin
        div_d      = tick ? '0 : div_q + DIV_W'(1);
        row_d      = row_q;
        acc_hits_d = acc_hits_q;
        acc_key_d  = acc_key_q;
        if (tick) begin
            row_d      = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
            acc_hits_d = frame_end ? 2'd0 : frame_hits;
            acc_key_d  = frame_end ? '0 : frame_key;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        accept  = 1'b0;
        if (frame_end) begin
            unique case (state_q)
                StIdle: begin
                    if (frame_hits == 2'd1) begin
                        key_d = frame_key;
                        cnt_d = CNT_W'(1);
                        if (DEBOUNCE == 1) begin
                            accept  = 1'b1;
                            state_d = StHeld;
                            rcnt_d  = '0;
                        end else begin
                            state_d = StCand;
                        end
                    end
                end
                StCand: begin
                    if (frame_hits == 2'd1 && frame_key == key_q) begin
                        if (32'(cnt_q) + 32'd1 == DEBOUNCE) begin
                            accept  = 1'b1;
                            state_d = StHeld;
                            rcnt_d  = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (frame_hits == 2'd1) begin
                        key_d = frame_key;
                        cnt_d = CNT_W'(1);
                    end else begin
                        state_d = StIdle;
                    end
                end
                StHeld: begin
                    if (frame_hits == 2'd0) begin
                        if (32'(rcnt_q) + 32'd1 == DEBOUNCE) begin
                            state_d = StIdle;
                            rcnt_d  = '0;
                        end else begin
                            rcnt_d = rcnt_q + CNT_W'(1);
                        end
                    end else begin
                        rcnt_d = '0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        push_req_d  = accept;
        push_code_d = accept ? key_d : push_code_q;
    end

    // A push into a full FIFO still succeeds when the same cycle pops the head.
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FCNT_W'(FIFO_DEPTH));
        pop_en     = POP && !fifo_empty;
        push_en    = push_req_q && (!fifo_full || pop_en);
        overflow_d = overflow_q || (push_req_q && fifo_full && !pop_en);
        wr_ptr_d   = push_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push_en && !pop_en) count_d = count_q + FCNT_W'(1);
        if (pop_en && !push_en) count_d = count_q - FCNT_W'(1);
        if (push_en)                 int_cnt_d = INT_W'(INT_CYCLES);
        else if (int_cnt_q != '0)    int_cnt_d = int_cnt_q - INT_W'(1);
        else                         int_cnt_d = '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            col_meta_q  <= '1;
            col_sync_q  <= '1;
            div_q       <= '0;
            row_q       <= '0;
            acc_hits_q  <= 2'd0;
            acc_key_q   <= '0;
            state_q     <= StIdle;
            key_q       <= '0;
            cnt_q       <= '0;
            rcnt_q      <= '0;
            push_req_q  <= 1'b0;
            push_code_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            int_cnt_q   <= '0;
        end else begin
            col_meta_q  <= COL_IN;
            col_sync_q  <= col_meta_q;
            div_q       <= div_d;
            row_q       <= row_d;
            acc_hits_q  <= acc_hits_d;
            acc_key_q   <= acc_key_d;
            state_q     <= state_d;
            key_q       <= key_d;
            cnt_q       <= cnt_d;
            rcnt_q      <= rcnt_d;
            push_req_q  <= push_req_d;
            push_code_q <= push_code_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            int_cnt_q   <= int_cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_en) fifo_mem_q[wr_ptr_q] <= push_code_q;
    end

    assign ROW_OUT   = ~(ROWS'(1) << row_q);
    assign VALID     = !fifo_empty;
    assign DATA      = fifo_empty ? '0 : fifo_mem_q[rd_ptr_q];
    assign INTERRUPT = (int_cnt_q != '0);
    assign OVERFLOW  = overflow_q;

endmodule
